iir_sos_sequencer: RTL

- Time-multiplexed scheduler for the cascade SOS IIR: one shared biquad section datapath is stepped through IIR_SOS_NUM sections for every input sample.
- Per section: drives the section index (coefficient-bank and state-bank select), issues a start pulse with the section input, waits for done, and forwards the result to the next section.
- Sits between the sample source/sink (valid/ready streams) and the shared section datapath plus coefficient store.
- Also sequences delay-line clearing and reports datapath timeouts.

---
 rtl/iir_sos_sequencer_if.sv | 47 ++++
 rtl/iir_sos_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_sequencer_if
// Purpose  : Bundles the sample streams, the shared biquad section handshake
//            and the flush/error controls of the SOS IIR scheduler.
//            The master modport is the scheduler's view. The slave modport is
//            the view of the surrounding source, sink and section datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface iir_sos_sequencer_if #(
   parameter int IIR_WD = 48,
   parameter int IDX_WD = 3
) ();
   // sample source stream
   logic              s_valid;
   logic              s_ready;
   logic [IIR_WD-1:0] s_data;
   // filtered sample sink stream
   logic              m_valid;
   logic              m_ready;
   logic [IIR_WD-1:0] m_data;
   // shared section datapath
   logic [IDX_WD-1:0] sec_idx;
   logic              sec_start;
   logic [IIR_WD-1:0] sec_x;
   logic              sec_done;
   logic [IIR_WD-1:0] sec_y;
   logic              state_clr;
   // control and status
   logic              flush;
   logic              busy;
   logic              err_timeout;
   logic              err_clr;

   modport master (
      input  s_valid, s_data, m_ready, sec_done, sec_y, flush, err_clr,
      output s_ready, m_valid, m_data, sec_idx, sec_start, sec_x, state_clr,
             busy, err_timeout
   );

   modport slave (
      output s_valid, s_data, m_ready, sec_done, sec_y, flush, err_clr,
      input  s_ready, m_valid, m_data, sec_idx, sec_start, sec_x, state_clr,
             busy, err_timeout
   );
endinterface
`default_nettype wire

// File: rtl/iir_sos_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_sequencer
// Purpose  : Time-multiplexed scheduler for a cascade of second-order IIR
//            sections. It steps one shared biquad datapath through
//            IIR_SOS_NUM sections for each input sample. It also sequences
//            delay-line clearing on flush and aborts on datapath timeout.
// Revision : 1.0 - initial release
// ============================================================================
module iir_sos_sequencer #(
   parameter int IIR_WD      = 48,
   parameter int IIR_SOS_NUM = 6,
   parameter int TIMEOUT_CYC = 64,
   parameter int IDX_WD      = (IIR_SOS_NUM > 1) ? $clog2(IIR_SOS_NUM) : 1
) (
   input  wire logic           clk,
   input  wire logic           rst,
   iir_sos_sequencer_if.master bus
);

   localparam int CNT_WD = $clog2(TIMEOUT_CYC);

   localparam logic [IDX_WD-1:0] c_LAST_IDX = IDX_WD'(IIR_SOS_NUM - 1);
   localparam logic [CNT_WD-1:0] c_TMO_LAST = CNT_WD'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4,
      S_CLR   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IDX_WD-1:0] r_sec_idx;
   logic [IIR_WD-1:0] r_sec_x;
   logic [IIR_WD-1:0] r_m_data;
   logic [CNT_WD-1:0] r_tmo_cnt;
   logic              r_err_timeout;
   logic              r_flush_pend;

   logic              w_s_ready;
   logic              w_accept;
   logic              w_sec_start;
   logic              w_state_clr;
   logic              w_m_valid;
   logic              w_last_sec;
   logic              w_tmo_hit;

   assign w_last_sec = (r_sec_idx == c_LAST_IDX);
   assign w_tmo_hit  = (r_tmo_cnt == c_TMO_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_s_ready   = 1'b0;
      w_accept    = 1'b0;
      w_sec_start = 1'b0;
      w_state_clr = 1'b0;
      w_m_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A flush arriving in the same cycle wins over the sample, so
            // ready is withheld rather than silently dropping the sample.
            w_s_ready = !r_flush_pend && !bus.flush && !rst;
            w_accept  = w_s_ready && bus.s_valid;
            if (r_flush_pend || bus.flush) begin
               w_state_nxt = S_CLR;
            end else if (w_accept) begin
               w_state_nxt = S_SEL;
            end
         end
         S_SEL: begin
            w_state_nxt = S_START;
         end
         S_START: begin
            w_sec_start = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.sec_done) begin
               w_state_nxt = w_last_sec ? S_OUT : S_SEL;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_OUT: begin
            w_m_valid = 1'b1;
            if (bus.m_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLR: begin
            w_state_clr = 1'b1;
            if (w_last_sec) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Section index, section operand, result, timeout and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sec_idx     <= '0;
         r_sec_x       <= '0;
         r_m_data      <= '0;
         r_tmo_cnt     <= '0;
         r_err_timeout <= 1'b0;
         r_flush_pend  <= 1'b0;
      end else begin
         // A later timeout assignment below overrides this clear.
         if (bus.err_clr) begin
            r_err_timeout <= 1'b0;
         end
         // A flush during CLR is absorbed: the clear already in progress
         // leaves every section zeroed because no sample runs meanwhile.
         if (bus.flush && (r_state != S_IDLE) && (r_state != S_CLR)) begin
            r_flush_pend <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (r_flush_pend || bus.flush) begin
                  r_sec_idx    <= '0;
                  r_flush_pend <= 1'b0;
               end else if (w_accept) begin
                  r_sec_x   <= bus.s_data;
                  r_sec_idx <= '0;
               end
            end
            S_START: begin
               r_tmo_cnt <= '0;
            end
            S_WAIT: begin
               if (bus.sec_done) begin
                  r_sec_x <= bus.sec_y;
                  if (w_last_sec) begin
                     r_m_data <= bus.sec_y;
                  end else begin
                     r_sec_idx <= r_sec_idx + IDX_WD'(1);
                  end
               end else if (w_tmo_hit) begin
                  r_err_timeout <= 1'b1;
                  r_sec_idx     <= '0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + CNT_WD'(1);
               end
            end
            S_CLR: begin
               r_sec_idx <= w_last_sec ? '0 : r_sec_idx + IDX_WD'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.s_ready     = w_s_ready;
   assign bus.m_valid     = w_m_valid;
   assign bus.m_data      = r_m_data;
   assign bus.sec_idx     = r_sec_idx;
   assign bus.sec_start   = w_sec_start;
   assign bus.sec_x       = r_sec_x;
   assign bus.state_clr   = w_state_clr;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire
